grid_mover: RTL and testbench

- Parametrised tile-grid actor engine. Owns cell position, smooth pixel position, facing, walk animation phase and hit points for one player-type sprite.
- Queries the map through a registered request/acknowledge handshake.
- Takes damage from NUM_MON monsters on contact edges.
- Sits between the debounced button logic, the map/tile lookup and the VGA sprite renderer; it drives the renderer's position and frame-select inputs.

---
 rtl/grid_mover_pkg.sv | 14 +
 rtl/grid_hit_detector.sv | 62 ++++++
 rtl/grid_mover.sv | 122 ++++++++++++
 tb/tb_grid_mover.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/grid_mover_pkg.sv
// grid_mover_pkg: encodings shared by the grid_mover actor engine and its neighbours.
package grid_mover_pkg;
  typedef enum logic [1:0] {FACE_DOWN = 2'd0, FACE_UP = 2'd1, FACE_LEFT = 2'd2, FACE_RIGHT = 2'd3} facing_t;
  localparam int DIR_UP = 3, DIR_DOWN = 2, DIR_LEFT = 1, DIR_RIGHT = 0;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_QUERY = 2'd1, S_MOVE = 2'd2} state_t;
  typedef enum logic [1:0] {TILE_WALL = 2'd0, TILE_ROAD0 = 2'd1, TILE_ROAD1 = 2'd2, TILE_STAIRS = 2'd3} tile_t;
  localparam logic [7:0] TRANSPARENT = 8'hE3;
  function automatic logic tile_walkable(tile_t t);
    return t != TILE_WALL;
  endfunction
  function automatic logic is_transparent(logic [7:0] px);
    return px == TRANSPARENT;
  endfunction
endpackage

// File: rtl/grid_hit_detector.sv
// grid_hit_detector: per-monster contact edge detection and saturating hit-point bookkeeping.
// GRID_MOVER_INVULN_EN adds a post-hit invulnerability window of INVULN_CYC cycles.
module grid_hit_detector
  import grid_mover_pkg::*;
#(
  parameter int POS_W   = 10,
  parameter int NUM_MON = 4,
  parameter int HP_W    = 5,
  parameter int HP_FULL = 5,
  parameter int DAMAGE  = 1
`ifdef GRID_MOVER_INVULN_EN
  , parameter int INVULN_CYC = 4096
`endif
) (
  input  logic                     clk_13,
  input  logic                     rst_n,
  input  logic                     load_en,
  input  logic [POS_W-1:0]         pos_r,
  input  logic [POS_W-1:0]         pos_c,
  input  logic [NUM_MON*POS_W-1:0] mon_r,
  input  logic [NUM_MON*POS_W-1:0] mon_c,
  input  logic [NUM_MON-1:0]       mon_alive,
  output logic [HP_W-1:0]          hp,
  output logic                     hit_pulse,
  output logic                     invuln
);
  localparam int DW = HP_W + $clog2(NUM_MON) + 1;
  logic [NUM_MON-1:0] overlap, hist, hit;
  logic [DW-1:0] k, dmg;
  logic applied;
  always_comb begin
    overlap = '0;
    for (int i = 0; i < NUM_MON; i++)
      overlap[i] = mon_alive[i] && mon_r[i*POS_W +: POS_W] == pos_r && mon_c[i*POS_W +: POS_W] == pos_c;
    hit = overlap & ~hist & {NUM_MON{!invuln}};
    k = '0;
    for (int i = 0; i < NUM_MON; i++)
      k = k + DW'(hit[i]);
    dmg = k * DW'(DAMAGE);
    applied = k != '0 && hp != '0;
  end
  always_ff @(posedge clk_13 or negedge rst_n)
    if (!rst_n) begin
      hist      <= '0;
      hp        <= HP_W'(HP_FULL);
      hit_pulse <= 1'b0;
    end else begin
      hist      <= load_en ? '0 : overlap;
      hp        <= DW'(hp) > dmg ? hp - HP_W'(dmg) : '0;
      hit_pulse <= applied;
    end
`ifdef GRID_MOVER_INVULN_EN
  localparam int CW = $clog2(INVULN_CYC + 1);
  logic [CW-1:0] cnt;
  always_ff @(posedge clk_13 or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load_en ? '0 : applied ? CW'(INVULN_CYC) : cnt - CW'(cnt != '0);
  assign invuln = cnt != '0;
`else
  assign invuln = 1'b0;
`endif
endmodule

// File: rtl/grid_mover.sv
// grid_mover: tile-grid player actor with map query handshake, smooth pixel stepping and contact damage.
// GRID_MOVER_INVULN_EN enables the post-hit invulnerability window.
module grid_mover
  import grid_mover_pkg::*;
#(
  parameter int POS_W    = 10,
  parameter int LOG_LEN  = 5,
  parameter int STEP_LOG = 5,
  parameter int NUM_MON  = 4,
  parameter int HP_W     = 5,
  parameter int HP_FULL  = 5,
  parameter int DAMAGE   = 1,
  parameter int START_R  = 3,
  parameter int START_C  = 3
`ifdef GRID_MOVER_INVULN_EN
  , parameter int INVULN_CYC = 4096
`endif
) (
  input  logic                     clk_13,
  input  logic                     rst_n,
  input  logic [3:0]               dir_req,
  input  logic                     load_en,
  input  logic [POS_W-1:0]         load_r,
  input  logic [POS_W-1:0]         load_c,
  output logic                     dest_req,
  output logic [POS_W-1:0]         dest_r,
  output logic [POS_W-1:0]         dest_c,
  input  logic                     dest_ack,
  input  logic                     dest_ok,
  input  logic [NUM_MON*POS_W-1:0] mon_r,
  input  logic [NUM_MON*POS_W-1:0] mon_c,
  input  logic [NUM_MON-1:0]       mon_alive,
  output logic [POS_W-1:0]         pos_r,
  output logic [POS_W-1:0]         pos_c,
  output logic [POS_W-1:0]         pix_v,
  output logic [POS_W-1:0]         pix_h,
  output logic [1:0]               facing,
  output logic                     moving,
  output logic [1:0]               anim_frame,
  output logic [HP_W-1:0]          hp,
  output logic                     alive,
  output logic                     hit_pulse,
  output logic                     invuln
);
  state_t state, state_nx;
  logic [1:0] want;
  logic go, under, wrap, last;
  logic [LOG_LEN-1:0] px_cnt;
  logic [STEP_LOG-1:0] sub_cnt;
  always_comb begin
    want  = dir_req[DIR_UP] ? FACE_UP : dir_req[DIR_DOWN] ? FACE_DOWN : dir_req[DIR_LEFT] ? FACE_LEFT : FACE_RIGHT;
    go    = alive && |dir_req;
    under = (want == FACE_UP && pos_r == '0) || (want == FACE_LEFT && pos_c == '0);
    wrap  = &sub_cnt;
    last  = wrap && &px_cnt;
  end
  always_ff @(posedge clk_13 or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    if (load_en) state_nx = S_IDLE;
    else if (state == S_IDLE) state_nx = go && !under ? S_QUERY : S_IDLE;
    else if (state == S_QUERY) state_nx = !dest_ack ? S_QUERY : dest_ok ? S_MOVE : S_IDLE;
    else state_nx = last ? S_IDLE : S_MOVE;
  end
  always_comb begin
    dest_req   = state == S_QUERY;
    moving     = state == S_MOVE;
    anim_frame = !moving ? 2'd0 : px_cnt[LOG_LEN-1] ? 2'd2 : 2'd1;
    alive      = hp != '0;
  end
  // The final pixel wrap snaps to the destination cell so pix never drifts from pos.
  always_ff @(posedge clk_13 or negedge rst_n)
    if (!rst_n) begin
      pos_r   <= POS_W'(START_R);
      pos_c   <= POS_W'(START_C);
      pix_v   <= POS_W'(START_R) << LOG_LEN;
      pix_h   <= POS_W'(START_C) << LOG_LEN;
      dest_r  <= POS_W'(START_R);
      dest_c  <= POS_W'(START_C);
      facing  <= FACE_DOWN;
      px_cnt  <= '0;
      sub_cnt <= '0;
    end else if (load_en) begin
      pos_r <= load_r;
      pos_c <= load_c;
      pix_v <= load_r << LOG_LEN;
      pix_h <= load_c << LOG_LEN;
    end else if (state == S_IDLE) begin
      if (go) facing <= want;
      if (go && !under) begin
        dest_r <= want == FACE_UP ? pos_r - 1'b1 : want == FACE_DOWN ? pos_r + 1'b1 : pos_r;
        dest_c <= want == FACE_LEFT ? pos_c - 1'b1 : want == FACE_RIGHT ? pos_c + 1'b1 : pos_c;
      end
    end else if (state == S_QUERY) begin
      px_cnt  <= '0;
      sub_cnt <= '0;
    end else begin
      sub_cnt <= sub_cnt + 1'b1;
      if (last) begin
        pos_r <= dest_r;
        pos_c <= dest_c;
        pix_v <= dest_r << LOG_LEN;
        pix_h <= dest_c << LOG_LEN;
      end else if (wrap) begin
        px_cnt <= px_cnt + 1'b1;
        pix_v  <= facing == FACE_UP ? pix_v - 1'b1 : facing == FACE_DOWN ? pix_v + 1'b1 : pix_v;
        pix_h  <= facing == FACE_LEFT ? pix_h - 1'b1 : facing == FACE_RIGHT ? pix_h + 1'b1 : pix_h;
      end
    end
  grid_hit_detector #(
    .POS_W(POS_W), .NUM_MON(NUM_MON), .HP_W(HP_W), .HP_FULL(HP_FULL), .DAMAGE(DAMAGE)
`ifdef GRID_MOVER_INVULN_EN
    , .INVULN_CYC(INVULN_CYC)
`endif
  ) u_hit (
    .clk_13(clk_13), .rst_n(rst_n), .load_en(load_en), .pos_r(pos_r), .pos_c(pos_c),
    .mon_r(mon_r), .mon_c(mon_c), .mon_alive(mon_alive),
    .hp(hp), .hit_pulse(hit_pulse), .invuln(invuln)
  );
endmodule

// File: tb/tb_grid_mover.sv
// tb_grid_mover: directed checks of movement, map handshake, teleport and contact damage
// with STEP_LOG=1 (64 cycles per move).
module tb_grid_mover;
  localparam int PW = 10, NM = 4;
`ifdef GRID_MOVER_INVULN_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  logic clk_13 = 1'b0, rst_n = 1'b0;
  logic [3:0] dir_req = '0;
  logic load_en = 1'b0;
  logic [PW-1:0] load_r = '0, load_c = '0;
  logic dest_req, dest_ack = 1'b0, dest_ok = 1'b0;
  logic [PW-1:0] dest_r, dest_c, pos_r, pos_c, pix_v, pix_h;
  logic [NM*PW-1:0] mon_r = '0, mon_c = '0;
  logic [NM-1:0] mon_alive = '0;
  logic [1:0] facing, anim_frame;
  logic moving, alive, hit_pulse, invuln;
  logic [4:0] hp;
  int vecs = 0, errs = 0;

  always #5 clk_13 = ~clk_13;

  grid_mover #(
    .STEP_LOG(1)
`ifdef GRID_MOVER_INVULN_EN
    , .INVULN_CYC(50)
`endif
  ) dut (
    .clk_13(clk_13), .rst_n(rst_n), .dir_req(dir_req), .load_en(load_en), .load_r(load_r), .load_c(load_c),
    .dest_req(dest_req), .dest_r(dest_r), .dest_c(dest_c), .dest_ack(dest_ack), .dest_ok(dest_ok),
    .mon_r(mon_r), .mon_c(mon_c), .mon_alive(mon_alive), .pos_r(pos_r), .pos_c(pos_c),
    .pix_v(pix_v), .pix_h(pix_h), .facing(facing), .moving(moving), .anim_frame(anim_frame),
    .hp(hp), .alive(alive), .hit_pulse(hit_pulse), .invuln(invuln)
  );

  task automatic cyc(int n);
    repeat (n) @(negedge clk_13);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic mon_set(int i, int r, int c, bit a);
    mon_r[i*PW +: PW] = PW'(r);
    mon_c[i*PW +: PW] = PW'(c);
    mon_alive[i] = a;
  endtask

  task automatic teleport(int r, int c);
    load_en = 1'b1; load_r = PW'(r); load_c = PW'(c);
    cyc(1);
    load_en = 1'b0;
  endtask

  task automatic answer(bit ok);
    dest_ack = 1'b1; dest_ok = ok;
    cyc(1);
    dest_ack = 1'b0; dest_ok = 1'b0;
  endtask

  // Monster 0 steps off the player's cell (3,3) and back: one new contact edge.
  task automatic bounce();
    mon_set(0, 4, 3, 1'b1);
    cyc(1);
    mon_set(0, 3, 3, 1'b1);
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc(2);
    chk("rst_pos_r", pos_r, 3);
    chk("rst_pos_c", pos_c, 3);
    chk("rst_pix_v", pix_v, 96);
    chk("rst_pix_h", pix_h, 96);
    chk("rst_facing", facing, 0);
    chk("rst_dest_req", dest_req, 0);
    chk("rst_dest_r", dest_r, 3);
    chk("rst_moving", moving, 0);
    chk("rst_anim", anim_frame, 0);
    chk("rst_hp", hp, 5);
    chk("rst_alive", alive, 1);
    chk("rst_hit_pulse", hit_pulse, 0);
    chk("rst_invuln", invuln, 0);
    rst_n = 1'b1;
    cyc(1);
    // right move (3,3) -> (3,4)
    dir_req = 4'b0001;
    cyc(1);
    dir_req = '0;
    chk("q_req", dest_req, 1);
    chk("q_dest_r", dest_r, 3);
    chk("q_dest_c", dest_c, 4);
    chk("q_facing", facing, 3);
    cyc(2);
    chk("q_req_held", dest_req, 1);
    chk("q_dest_held", dest_c, 4);
    answer(1'b1);
    chk("mv_moving", moving, 1);
    chk("mv_req_drop", dest_req, 0);
    chk("mv_anim_k0", anim_frame, 1);
    chk("mv_pix_k0", pix_h, 96);
    cyc(31);
    chk("mv_anim_k31", anim_frame, 1);
    chk("mv_pix_k31", pix_h, 111);
    cyc(1);
    chk("mv_anim_k32", anim_frame, 2);
    chk("mv_pix_k32", pix_h, 112);
    cyc(31);
    chk("mv_pos_k63", pos_c, 3);
    chk("mv_pix_k63", pix_h, 127);
    chk("mv_moving_k63", moving, 1);
    cyc(1);
    chk("mv_pos_done", pos_c, 4);
    chk("mv_pix_done", pix_h, 128);
    chk("mv_pix_v", pix_v, 96);
    chk("mv_moving_done", moving, 0);
    chk("mv_anim_done", anim_frame, 0);
    // stray ack in IDLE
    answer(1'b1);
    chk("idle_ack_moving", moving, 0);
    chk("idle_ack_req", dest_req, 0);
    // priority: all buttons -> up, map refuses
    dir_req = 4'b1111;
    cyc(1);
    dir_req = '0;
    chk("pri_facing_up", facing, 1);
    chk("pri_dest_r", dest_r, 2);
    chk("pri_dest_c", dest_c, 4);
    answer(1'b0);
    chk("blk_req", dest_req, 0);
    chk("blk_moving", moving, 0);
    chk("blk_pos_r", pos_r, 3);
    chk("blk_pix_v", pix_v, 96);
    dir_req = 4'b0110;
    cyc(1);
    dir_req = '0;
    chk("pri_facing_down", facing, 0);
    chk("pri_dest_down", dest_r, 4);
    answer(1'b0);
    // up at row 0
    teleport(0, 5);
    chk("tp0_pos_r", pos_r, 0);
    chk("tp0_pos_c", pos_c, 5);
    chk("tp0_pix_v", pix_v, 0);
    chk("tp0_pix_h", pix_h, 160);
    chk("tp0_facing", facing, 0);
    dir_req = 4'b1000;
    cyc(1);
    chk("row0_req", dest_req, 0);
    chk("row0_facing", facing, 1);
    cyc(3);
    chk("row0_req_later", dest_req, 0);
    dir_req = '0;
    // held right for three moves
    teleport(3, 3);
    dir_req = 4'b0001;
    for (int m = 0; m < 3; m++) begin
      cyc(1);
      chk("hold_req", dest_req, 1);
      chk("hold_dest_c", dest_c, 4 + m);
      answer(1'b1);
      cyc(64);
      chk("hold_pos_c", pos_c, 4 + m);
      chk("hold_idle", moving, 0);
    end
    dir_req = '0;
    chk("hold_pix_h", pix_h, 192);
    // teleport mid-move at px_cnt=17
    dir_req = 4'b0001;
    cyc(1);
    dir_req = '0;
    answer(1'b1);
    cyc(34);
    chk("tpm_anim", anim_frame, 2);
    chk("tpm_pix_h", pix_h, 209);
    teleport(10, 2);
    chk("tpm_pos_r", pos_r, 10);
    chk("tpm_pos_c", pos_c, 2);
    chk("tpm_pix_v", pix_v, 320);
    chk("tpm_pix_h_load", pix_h, 64);
    chk("tpm_moving", moving, 0);
    chk("tpm_req", dest_req, 0);
    chk("tpm_hp", hp, 5);
    chk("tpm_facing", facing, 3);
    cyc(70);
    chk("tpm_still_pos", pos_c, 2);
    chk("tpm_still_pix", pix_h, 64);
    // damage
    teleport(3, 3);
    mon_set(0, 3, 3, 1'b1);
    mon_set(1, 3, 3, 1'b1);
    cyc(1);
    chk("dmg2_hp", hp, 3);
    chk("dmg2_pulse", hit_pulse, 1);
    chk("dmg2_invuln", invuln, INV ? 1 : 0);
    cyc(1);
    chk("dmg2_pulse_once", hit_pulse, 0);
    chk("dmg2_hp_hold", hp, 3);
    cyc(100);
    chk("overlap_hp", hp, 3);
    chk("overlap_invuln", invuln, 0);
    bounce();
    chk("edge1_hp", hp, 2);
    chk("edge1_pulse", hit_pulse, 1);
    chk("edge1_invuln", invuln, INV ? 1 : 0);
    cyc(18);
    bounce();
    chk("edge_t20_hp", hp, INV ? 2 : 1);
    chk("edge_t20_pulse", hit_pulse, INV ? 0 : 1);
    cyc(38);
    bounce();
    chk("edge_t60_hp", hp, INV ? 1 : 0);
    chk("edge_t60_invuln", invuln, INV ? 1 : 0);
    cyc(60);
    bounce();
    chk("last_hp", hp, 0);
    chk("last_pulse", hit_pulse, INV ? 1 : 0);
    chk("dead_alive", alive, 0);
    cyc(60);
    bounce();
    chk("dead_edge_hp", hp, 0);
    chk("dead_edge_pulse", hit_pulse, 0);
    dir_req = 4'b0001;
    cyc(3);
    chk("dead_req", dest_req, 0);
    chk("dead_moving", moving, 0);
    chk("dead_pos_c", pos_c, 3);
    dir_req = '0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
